// File: rtl/depth_weight_fetcher_pkg.sv
// Shared constants and FSM encoding for the depthwise weight fetch path.
// Word and address widths match the depthwise weight memory.
package depth_weight_fetcher_pkg;

    localparam int BITSIZE_DEF    = 14;
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int CH_WIDTH_DEF   = 10;
    localparam int TAPS_3X3       = 9;
    localparam int TAPS_5X5       = 25;
    localparam int MAX_TAPS       = TAPS_5X5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPT,
        ST_PRESENT,
        ST_DONE
    } fetch_state_t;

    function automatic int taps_of(input logic k5);
        return k5 ? TAPS_5X5 : TAPS_3X3;
    endfunction

endpackage

// File: rtl/depth_weight_fetcher_if.sv
// Weight memory read port plus packed-kernel valid/ready stream.
// master = fetcher side, slave = memory / PE-array side.
interface depth_weight_fetcher_if #(
    parameter int BITSIZE    = depth_weight_fetcher_pkg::BITSIZE_DEF,
    parameter int ADDR_WIDTH = depth_weight_fetcher_pkg::ADDR_WIDTH_DEF,
    parameter int CH_WIDTH   = depth_weight_fetcher_pkg::CH_WIDTH_DEF,
    parameter int MAX_TAPS   = depth_weight_fetcher_pkg::MAX_TAPS
);
    logic                         mem_en;
    logic                         mem_rd;
    logic [ADDR_WIDTH-1:0]        mem_index;
    logic [BITSIZE-1:0]           mem_data;
    logic                         kern_valid;
    logic                         kern_ready;
    logic [MAX_TAPS*BITSIZE-1:0]  kern_data;
    logic [CH_WIDTH-1:0]          kern_ch;

    modport master (
        output mem_en, mem_rd, mem_index,
        input  mem_data,
        output kern_valid, kern_data, kern_ch,
        input  kern_ready
    );

    modport slave (
        input  mem_en, mem_rd, mem_index,
        output mem_data,
        input  kern_valid, kern_data, kern_ch,
        output kern_ready
    );
endinterface

// File: rtl/depth_weight_fetcher_packer.sv
// Kernel lane register: cleared when a fetch begins, one lane written per
// captured word, otherwise held. Lane i sits at bits [i*BITSIZE +: BITSIZE].
module depth_kernel_packer #(
    parameter int BITSIZE  = depth_weight_fetcher_pkg::BITSIZE_DEF,
    parameter int MAX_TAPS = depth_weight_fetcher_pkg::MAX_TAPS,
    parameter int TAP_W    = $clog2(MAX_TAPS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [TAP_W-1:0]            wr_lane,
    input  logic [BITSIZE-1:0]          wr_data,
    output logic [MAX_TAPS*BITSIZE-1:0] kern_data
);
    logic [MAX_TAPS-1:0][BITSIZE-1:0] lanes;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lanes <= '0;
        end else if (wr_en) begin
            lanes[wr_lane] <= wr_data;
        end
    end

    assign kern_data = lanes;

endmodule

// File: rtl/depth_weight_fetcher.sv
// Reads one KxK depthwise kernel per channel from weight memory, packs it,
// and presents it to the PE array over valid/ready.
//   state   | meaning
//   IDLE    | waiting for start
//   FETCH   | issuing TAPS consecutive reads
//   CAPT    | capturing the last tap returned by memory
//   PRESENT | kern_valid high, waiting for kern_ready
//   DONE    | one-cycle done pulse
module depth_weight_fetcher #(
    parameter int BITSIZE    = depth_weight_fetcher_pkg::BITSIZE_DEF,
    parameter int ADDR_WIDTH = depth_weight_fetcher_pkg::ADDR_WIDTH_DEF,
    parameter int CH_WIDTH   = depth_weight_fetcher_pkg::CH_WIDTH_DEF,
    parameter int MAX_TAPS   = depth_weight_fetcher_pkg::MAX_TAPS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CH_WIDTH-1:0]   num_ch,
    input  logic                  k5,
    output logic                  busy,
    output logic                  done,
    depth_weight_fetcher_if.master bus
);
    import depth_weight_fetcher_pkg::*;

    localparam int TAP_W = $clog2(MAX_TAPS);

    fetch_state_t state, state_nxt;

    logic [TAP_W-1:0]            taps_q, tap_cnt, tap_cnt_d;
    logic [CH_WIDTH-1:0]         num_ch_q, ch_q, kern_ch_q;
    logic [CH_WIDTH:0]           ch_inc;
    logic [ADDR_WIDTH-1:0]       mem_index_q;
    logic                        mem_en_q, rd_d, kern_valid_q, busy_q, done_q;
    logic                        last_rd, accept, more_ch, fetch_begin;
    logic                        mem_en_nxt, kern_valid_nxt, busy_nxt, done_nxt;
    logic [MAX_TAPS*BITSIZE-1:0] kern_data_w;

    assign last_rd = (tap_cnt == taps_q - TAP_W'(1));
    assign accept  = kern_valid_q & bus.kern_ready;
    assign ch_inc  = {1'b0, ch_q} + (CH_WIDTH+1)'(1);
    assign more_ch = (ch_inc < {1'b0, num_ch_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start) state_nxt = (num_ch != '0) ? ST_FETCH : ST_DONE;
            ST_FETCH:   if (last_rd) state_nxt = ST_CAPT;
            ST_CAPT:    state_nxt = ST_PRESENT;
            ST_PRESENT: if (accept) state_nxt = more_ch ? ST_FETCH : ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        mem_en_nxt     = (state_nxt == ST_FETCH);
        kern_valid_nxt = (state_nxt == ST_PRESENT);
        busy_nxt       = (state_nxt inside {ST_FETCH, ST_CAPT, ST_PRESENT});
        done_nxt       = (state_nxt == ST_DONE);
        fetch_begin    = (state_nxt == ST_FETCH) && (state != ST_FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q     <= 1'b0;
            kern_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_d         <= 1'b0;
            tap_cnt      <= '0;
            tap_cnt_d    <= '0;
            taps_q       <= '0;
            num_ch_q     <= '0;
            ch_q         <= '0;
            kern_ch_q    <= '0;
            mem_index_q  <= '0;
        end else begin
            mem_en_q     <= mem_en_nxt;
            kern_valid_q <= kern_valid_nxt;
            busy_q       <= busy_nxt;
            done_q       <= done_nxt;
            rd_d         <= mem_en_q;
            tap_cnt_d    <= tap_cnt;
            if (state == ST_IDLE && start) begin
                taps_q      <= TAP_W'(taps_of(k5));
                num_ch_q    <= num_ch;
                ch_q        <= '0;
                mem_index_q <= base_addr;
                tap_cnt     <= '0;
            end
            // Index keeps counting across channels; it wraps modulo 2^ADDR_WIDTH.
            if (state == ST_FETCH) begin
                mem_index_q <= mem_index_q + ADDR_WIDTH'(1);
                tap_cnt     <= last_rd ? '0 : tap_cnt + TAP_W'(1);
            end
            if (state == ST_CAPT) begin
                kern_ch_q <= ch_q;
            end
            if (state == ST_PRESENT && accept && more_ch) begin
                ch_q <= ch_inc[CH_WIDTH-1:0];
            end
        end
    end

    depth_kernel_packer #(
        .BITSIZE  (BITSIZE),
        .MAX_TAPS (MAX_TAPS),
        .TAP_W    (TAP_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (fetch_begin),
        .wr_en     (rd_d),
        .wr_lane   (tap_cnt_d),
        .wr_data   (bus.mem_data),
        .kern_data (kern_data_w)
    );

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_rd     = mem_en_q;
    assign bus.mem_index  = mem_index_q;
    assign bus.kern_valid = kern_valid_q;
    assign bus.kern_data  = kern_data_w;
    assign bus.kern_ch    = kern_ch_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_depth_weight_fetcher.sv
// Bench for depth_weight_fetcher: directed layers plus randomized layers,
// all checked cycle by cycle against a queue-based model of reads and kernels.
module tb_depth_weight_fetcher;

    localparam int BW  = 14;
    localparam int KW  = 25 * BW;
    localparam int BIG = 32'h7fffffff;

    typedef struct {
        logic [KW-1:0] data;
        logic [9:0]    ch;
    } kern_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [9:0]  num_ch;
    logic        k5;
    logic        busy;
    logic        done;

    depth_weight_fetcher_if bus ();

    depth_weight_fetcher dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_ch    (num_ch),
        .k5        (k5),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [BW-1:0] mem [4096];
    logic [11:0]   exp_rd[$];
    kern_t         exp_kern[$];

    int t_start, fetch_origin, rd_in_ch, run_taps, run_reads, kern_idx;
    int first_valid_lat, acc_wait, valid_start, exp_done_cyc;
    bit valid_seen = 0, run_active = 0, mon_en = 0;
    int ready_mode = 0;
    int vcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: one-cycle registered read.
    initial bus.mem_data = '0;
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_index];

    initial bus.kern_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bus.kern_valid) vcnt++; else vcnt = 0;
        case (ready_mode)
            0: bus.kern_ready = 1'b1;
            1: bus.kern_ready = 1'($urandom_range(0, 1));
            default: bus.kern_ready = (vcnt >= 8);
        endcase
    end

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk(bus.mem_rd == bus.mem_en, "rd_eq_en", longint'(bus.mem_rd), longint'(bus.mem_en));
            if (bus.mem_rd) begin
                run_reads++;
                if (exp_rd.size() == 0) begin
                    chk(1'b0, "unexpected_read", longint'(bus.mem_index), 0);
                end else begin
                    chk(bus.mem_index == exp_rd[0], "read_index", longint'(bus.mem_index), longint'(exp_rd[0]));
                    chk(cyc == fetch_origin + 1 + rd_in_ch, "read_cycle", cyc, fetch_origin + 1 + rd_in_ch);
                    void'(exp_rd.pop_front());
                    rd_in_ch++;
                end
            end
            if (bus.kern_valid) begin
                chk(!bus.mem_rd, "fetch_overlap", longint'(bus.mem_rd), 0);
                if (exp_kern.size() == 0) begin
                    chk(1'b0, "unexpected_valid", 1, 0);
                end else begin
                    if (!valid_seen) begin
                        chk(cyc == fetch_origin + run_taps + 2, "valid_cycle", cyc, fetch_origin + run_taps + 2);
                        valid_seen  = 1'b1;
                        valid_start = cyc;
                        if (kern_idx == 0) first_valid_lat = cyc - t_start;
                    end
                    checks++;
                    if (bus.kern_data !== exp_kern[0].data) begin
                        failures++;
                        $display("FAIL kern_data ch=%0d: got %h expected %h", exp_kern[0].ch, bus.kern_data, exp_kern[0].data);
                    end
                    chk(bus.kern_ch == exp_kern[0].ch, "kern_ch", longint'(bus.kern_ch), longint'(exp_kern[0].ch));
                    if (bus.kern_ready) begin
                        acc_wait = cyc - valid_start;
                        void'(exp_kern.pop_front());
                        kern_idx++;
                        valid_seen = 1'b0;
                        if (exp_kern.size() != 0) begin
                            fetch_origin = cyc;
                            rd_in_ch     = 0;
                        end else begin
                            exp_done_cyc = cyc + 1;
                        end
                    end
                end
            end
            chk(busy == (run_active && cyc > t_start && cyc != exp_done_cyc), "busy",
                longint'(busy), longint'(run_active && cyc > t_start && cyc != exp_done_cyc));
            chk(done == (cyc == exp_done_cyc), "done", longint'(done), longint'(cyc == exp_done_cyc));
            if (run_active && cyc == exp_done_cyc) run_active = 1'b0;
        end
    end

    task automatic launch(input logic [11:0] b, input logic [9:0] n, input logic k);
        int    taps;
        kern_t kk;
        logic [11:0] a;
        taps = k ? 25 : 9;
        base_addr = b;
        num_ch    = n;
        k5        = k;
        start     = 1'b1;
        exp_rd.delete();
        exp_kern.delete();
        for (int c = 0; c < int'(n); c++) begin
            kk.data = '0;
            kk.ch   = c[9:0];
            for (int i = 0; i < taps; i++) begin
                a = b + 12'(c * taps + i);
                exp_rd.push_back(a);
                kk.data[i*BW +: BW] = mem[a];
            end
            exp_kern.push_back(kk);
        end
        t_start      = cyc;
        fetch_origin = cyc;
        rd_in_ch     = 0;
        run_taps     = taps;
        valid_seen   = 1'b0;
        run_reads    = 0;
        kern_idx     = 0;
        exp_done_cyc = (n == 0) ? cyc + 1 : BIG;
        run_active   = 1'b1;
    endtask

    task automatic finish_run(input int budget, input bit poke);
        int n;
        tick();
        start     = 1'b0;
        base_addr = 12'($urandom);
        num_ch    = 10'($urandom);
        k5        = 1'($urandom);
        n = 0;
        while (run_active && n < budget) begin
            start = (poke && n == 4);
            tick();
            n++;
        end
        start = 1'b0;
        chk(!run_active, "run_timeout", n, budget);
        chk(exp_rd.size() == 0, "reads_left", exp_rd.size(), 0);
        chk(exp_kern.size() == 0, "kernels_left", exp_kern.size(), 0);
    endtask

    task automatic chk_reset_vals();
        chk(bus.mem_en == 1'b0, "rst_mem_en", longint'(bus.mem_en), 0);
        chk(bus.mem_rd == 1'b0, "rst_mem_rd", longint'(bus.mem_rd), 0);
        chk(bus.mem_index == 12'h000, "rst_mem_index", longint'(bus.mem_index), 0);
        chk(bus.kern_valid == 1'b0, "rst_kern_valid", longint'(bus.kern_valid), 0);
        chk(bus.kern_data == '0, "rst_kern_data", longint'(bus.kern_data[63:0]), 0);
        chk(bus.kern_ch == 10'd0, "rst_kern_ch", longint'(bus.kern_ch), 0);
        chk(busy == 1'b0, "rst_busy", longint'(busy), 0);
        chk(done == 1'b0, "rst_done", longint'(done), 0);
    endtask

    task automatic fill_random();
        for (int n = 0; n < 4096; n++) mem[n] = 14'($urandom);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_ch = '0; k5 = 1'b0;
        repeat (3) tick();
        chk_reset_vals();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // 3x3, two channels, word n = n
        for (int n = 0; n < 4096; n++) mem[n] = 14'(n);
        ready_mode = 0;
        launch(12'h010, 10'd2, 1'b0);
        chk(exp_rd.size() == 18, "model_nreads", exp_rd.size(), 18);
        chk(exp_rd[0] == 12'h010, "model_rd0", longint'(exp_rd[0]), 'h010);
        chk(exp_rd[17] == 12'h021, "model_rd17", longint'(exp_rd[17]), 'h021);
        chk(exp_kern[0].data[0 +: BW] == 14'd16, "model_k0_l0", longint'(exp_kern[0].data[0 +: BW]), 16);
        chk(exp_kern[0].data[8*BW +: BW] == 14'd24, "model_k0_l8", longint'(exp_kern[0].data[8*BW +: BW]), 24);
        chk(exp_kern[0].data[KW-1:9*BW] == '0, "model_k0_hi", 1, 0);
        chk(exp_kern[1].data[0 +: BW] == 14'd25, "model_k1_l0", longint'(exp_kern[1].data[0 +: BW]), 25);
        chk(exp_kern[1].data[8*BW +: BW] == 14'd33, "model_k1_l8", longint'(exp_kern[1].data[8*BW +: BW]), 33);
        finish_run(200, 1'b0);
        chk(first_valid_lat == 11, "lat_3x3", first_valid_lat, 11);
        chk(run_reads == 18, "reads_3x3", run_reads, 18);

        // 5x5, one channel, word n = -n
        for (int n = 0; n < 4096; n++) mem[n] = 14'(-n);
        launch(12'h000, 10'd1, 1'b1);
        chk(exp_kern[0].data[1*BW +: BW] == 14'h3FFF, "model_neg1", longint'(exp_kern[0].data[1*BW +: BW]), 'h3FFF);
        chk(exp_kern[0].data[24*BW +: BW] == 14'h3FE8, "model_neg24", longint'(exp_kern[0].data[24*BW +: BW]), 'h3FE8);
        finish_run(200, 1'b0);
        chk(first_valid_lat == 27, "lat_5x5", first_valid_lat, 27);

        // backpressure: ready low for 7 valid cycles, accept on the 8th
        fill_random();
        ready_mode = 2;
        launch(12'h123, 10'd2, 1'b0);
        finish_run(300, 1'b0);
        chk(acc_wait == 7, "bp_accept_wait", acc_wait, 7);
        ready_mode = 0;

        // address wrap
        fill_random();
        launch(12'hFFC, 10'd1, 1'b0);
        chk(exp_rd[3] == 12'hFFF, "model_wrap3", longint'(exp_rd[3]), 'hFFF);
        chk(exp_rd[4] == 12'h000, "model_wrap4", longint'(exp_rd[4]), 0);
        chk(exp_rd[8] == 12'h004, "model_wrap8", longint'(exp_rd[8]), 4);
        finish_run(200, 1'b0);

        // zero channels
        launch(12'h055, 10'd0, 1'b0);
        finish_run(50, 1'b0);
        chk(run_reads == 0, "zero_ch_reads", run_reads, 0);

        // start pulse while busy is ignored
        fill_random();
        launch(12'h200, 10'd3, 1'b1);
        finish_run(400, 1'b1);

        // reset in the middle of a fetch
        fill_random();
        launch(12'h300, 10'd2, 1'b1);
        tick();
        start = 1'b0;
        repeat (4) tick();
        mon_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals();
        exp_rd.delete();
        exp_kern.delete();
        run_active   = 1'b0;
        exp_done_cyc = BIG;
        mon_en = 1'b1;
        repeat (10) tick();
        launch(12'h300, 10'd2, 1'b1);
        finish_run(300, 1'b0);
        chk(run_reads == 50, "reads_after_reset", run_reads, 50);

        // randomized layers
        for (int r = 0; r < 24; r++) begin
            fill_random();
            ready_mode = $urandom_range(0, 1);
            launch(12'($urandom), 10'($urandom_range(0, 4)), 1'($urandom));
            finish_run(1500, 1'($urandom_range(0, 1)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
